e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the five-stage MIPS pipeline.
- Sits beside the ALU and feeds the E/M pipeline register: mfhi/mflo results are muxed into the E-stage result ahead of that register.
- Owns the HI/LO registers and runs mult/multu/div/divu as multi-cycle operations.
- Exports start/busy so the D-stage hazard unit can stall MDU instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears state immediately).
- E_MDU_Op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 treated as none.
- E_RS  input  32  forwarded rs operand (dividend / multiplicand / mthi/mtlo source).
- E_RT  input  32  forwarded rt operand (divisor / multiplier).
- E_MDU_Start  output  1  combinational: E_MDU_Op is 1..4 this cycle.
- E_MDU_Busy  output  1  registered: a multi-cycle operation is in flight.
- E_MDU_Result  output  32  combinational: HI when op=5, LO when op=6, else 0.
- E_HI  output  32  current HI register.
- E_LO  output  32  current LO register.

Behaviour:
- Reset (reset==0, asynchronous): HI=0, LO=0, counter=0, pending HI/LO=0, so E_MDU_Busy=0 at once. Reset mid-operation aborts it with no HI/LO commit.
- Idle means counter==0.

Start of an operation:
- On a rising edge with op in 1..4 and idle: latch the result into pending_hi/pending_lo, computed from E_RS/E_RT at that edge.
- Load counter=MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).

Busy and commit:
- E_MDU_Busy = (counter!=0). It is high for exactly N cycles after the start edge.
- Each edge with counter!=0 decrements the counter.
- On the edge where the counter goes 1->0, HI<=pending_hi and LO<=pending_lo.
- HI/LO keep their old values while busy. New values are visible in the cycle busy first reads 0.

Arithmetic:
- mult: signed 32x32->64 product; HI=upper, LO=lower.
- multu: unsigned 32x32->64 product; HI=upper, LO=lower.
- div: signed, truncate toward zero; LO=quotient, HI=remainder (sign of dividend). 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned; LO=quotient, HI=remainder.
- Divisor==0 (div/divu): the counter still runs DIV_CYCLES, but no HI/LO change at commit (pending loaded from current HI/LO).

Moves:
- mthi/mtlo, when idle: HI<=E_RS or LO<=E_RS on the edge.
- Visible through E_HI/E_LO and mfhi/mflo from the next cycle.

Collisions:
- Any op 1..4, 7 or 8 arriving while busy is ignored (no state change); the hazard unit must prevent it.
- mfhi/mflo while busy return the old HI/LO.
- The hazard stall condition is E_MDU_Start | E_MDU_Busy, for MDU-class instructions in D.

Misc:
- No flush input: a started operation always completes; E/M clears do not affect it.
- A start on the same edge as commit cannot occur, since busy blocks it.

Test Plan:
- Reset: hold reset=0 mid-mult (counter=3) -> Busy=0 immediately, HI=LO=0, no later commit after release.
- Mult: mult RS=0xFFFFFFFE (-2), RT=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- Div: div RS=-7, RT=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu RS=7, RT=2 -> LO=3, HI=1.
- Divide by zero: after mthi 0x11/mtlo 0x22, divu RS=5, RT=0 -> 10 busy cycles, HI=0x11 and LO=0x22 unchanged. Overflow div 0x80000000/-1 -> LO=0x80000000, HI=0.
- Collision: during mult busy, issue mtlo RS=0xAA and a second mult -> both ignored, and mflo during busy returns the old LO. After commit, mflo returns the mult LO.
- Moves: mthi RS=0x1234 -> E_HI=0x1234 next cycle, and mfhi E_MDU_Result=0x1234. Ops 9-15 -> no state change, Start=0, Result=0.

Source files
------------

// File: rtl/e_mdu_if.sv
// Execute-stage multiply/divide unit bus: operation/operand inputs and HI/LO/status outputs.
interface e_mdu_if;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;

    logic [OP_W-1:0]   E_MDU_Op;
    logic [DATA_W-1:0] E_RS;
    logic [DATA_W-1:0] E_RT;
    logic              E_MDU_Start;
    logic              E_MDU_Busy;
    logic [DATA_W-1:0] E_MDU_Result;
    logic [DATA_W-1:0] E_HI;
    logic [DATA_W-1:0] E_LO;

    // Pipeline side: drives the decoded op and forwarded operands.
    modport master (
        output E_MDU_Op, E_RS, E_RT,
        input  E_MDU_Start, E_MDU_Busy, E_MDU_Result, E_HI, E_LO
    );

    // MDU side.
    modport slave (
        input  E_MDU_Op, E_RS, E_RT,
        output E_MDU_Start, E_MDU_Busy, E_MDU_Result, E_HI, E_LO
    );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO; the result is computed at the
// start edge, held in pending registers and committed when the busy countdown expires.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  mdu
);
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PROD_W     = 2 * DATA_W;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [DATA_W-1:0] hi_q, lo_q;
    logic [DATA_W-1:0] pend_hi_q, pend_lo_q;
    logic [CNT_W-1:0]  count_q;
    logic              busy_q;

    logic              start;
    logic [CNT_W-1:0]  load_count;
    logic [DATA_W-1:0] next_hi, next_lo;

    logic [PROD_W-1:0] prod_u, prod_s;
    logic              rs_neg, rt_neg, rt_zero;
    logic [DATA_W-1:0] rs_mag, rt_mag;
    logic [DATA_W-1:0] udiv_den, sdiv_den;
    logic [DATA_W-1:0] udiv_q, udiv_r;
    logic [DATA_W-1:0] sdiv_q_mag, sdiv_r_mag;
    logic [DATA_W-1:0] sdiv_q, sdiv_r;

    assign start = (mdu.E_MDU_Op == OP_MULT)  || (mdu.E_MDU_Op == OP_MULTU) ||
                   (mdu.E_MDU_Op == OP_DIV)   || (mdu.E_MDU_Op == OP_DIVU);

    // Full-width products; sign extension to 64 bits gives the signed product in the low half.
    assign prod_u = {{DATA_W{1'b0}}, mdu.E_RS} * {{DATA_W{1'b0}}, mdu.E_RT};
    assign prod_s = {{DATA_W{mdu.E_RS[DATA_W-1]}}, mdu.E_RS} *
                    {{DATA_W{mdu.E_RT[DATA_W-1]}}, mdu.E_RT};

    // Signed divide via magnitudes; a zero divisor is steered to 1 to keep the divider defined.
    always_comb begin
        rs_neg     = mdu.E_RS[DATA_W-1];
        rt_neg     = mdu.E_RT[DATA_W-1];
        rt_zero    = (mdu.E_RT == '0);
        rs_mag     = rs_neg ? DATA_W'(~mdu.E_RS + DATA_W'(1)) : mdu.E_RS;
        rt_mag     = rt_neg ? DATA_W'(~mdu.E_RT + DATA_W'(1)) : mdu.E_RT;
        udiv_den   = rt_zero ? DATA_W'(1) : mdu.E_RT;
        sdiv_den   = rt_zero ? DATA_W'(1) : rt_mag;
        udiv_q     = mdu.E_RS / udiv_den;
        udiv_r     = mdu.E_RS % udiv_den;
        sdiv_q_mag = rs_mag / sdiv_den;
        sdiv_r_mag = rs_mag % sdiv_den;
        sdiv_q     = (rs_neg ^ rt_neg) ? DATA_W'(~sdiv_q_mag + DATA_W'(1)) : sdiv_q_mag;
        sdiv_r     = rs_neg ? DATA_W'(~sdiv_r_mag + DATA_W'(1)) : sdiv_r_mag;
    end

    // Pending result selection; divide-by-zero re-commits the current HI/LO.
    always_comb begin
        next_hi    = hi_q;
        next_lo    = lo_q;
        load_count = CNT_W'(DIV_CYCLES);
        case (mdu.E_MDU_Op)
            OP_MULT: begin
                next_hi    = prod_s[PROD_W-1:DATA_W];
                next_lo    = prod_s[DATA_W-1:0];
                load_count = CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
                next_hi    = prod_u[PROD_W-1:DATA_W];
                next_lo    = prod_u[DATA_W-1:0];
                load_count = CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
                if (!rt_zero) begin
                    next_hi = sdiv_r;
                    next_lo = sdiv_q;
                end
            end
            OP_DIVU: begin
                if (!rt_zero) begin
                    next_hi = udiv_r;
                    next_lo = udiv_q;
                end
            end
            default: ;
        endcase
    end

    // Countdown, commit and move handling; everything but mf* is ignored while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
                hi_q   <= pend_hi_q;
                lo_q   <= pend_lo_q;
                busy_q <= 1'b0;
            end
        end else if (start) begin
            pend_hi_q <= next_hi;
            pend_lo_q <= next_lo;
            count_q   <= load_count;
            busy_q    <= 1'b1;
        end else if (mdu.E_MDU_Op == OP_MTHI) begin
            hi_q <= mdu.E_RS;
        end else if (mdu.E_MDU_Op == OP_MTLO) begin
            lo_q <= mdu.E_RS;
        end
    end

    always_comb begin
        mdu.E_MDU_Result = '0;
        case (mdu.E_MDU_Op)
            OP_MFHI: mdu.E_MDU_Result = hi_q;
            OP_MFLO: mdu.E_MDU_Result = lo_q;
            default: ;
        endcase
    end

    assign mdu.E_MDU_Start = start;
    assign mdu.E_MDU_Busy  = busy_q;
    assign mdu.E_HI        = hi_q;
    assign mdu.E_LO        = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: a cycle-level arithmetic model predicts outputs, a monitor compares.
module tb_e_mdu;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    typedef struct {
        logic        start;
        logic [31:0] result;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    e_mdu_if intf ();

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (intf.slave)
    );

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    // model state
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    int          m_rem = 0;
    // inputs as seen by the DUT at the upcoming edge
    logic [3:0]  d_op = '0;
    logic [31:0] d_rs = '0, d_rt = '0;
    logic        d_reset = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural effect of one rising edge.
    task automatic model_edge(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                              input logic rstn);
        longint          sa, sb_, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     p;
        if (!rstn) begin
            m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else begin
            sa = longint'($signed(rs));
            sb_ = longint'($signed(rt));
            ua = longint'(rs);
            ub = longint'(rt);
            case (op)
                4'd1: begin p = 64'(sa * sb_); m_phi = p[63:32]; m_plo = p[31:0]; m_rem = MC; end
                4'd2: begin up = ua * ub; p = 64'(up); m_phi = p[63:32]; m_plo = p[31:0]; m_rem = MC; end
                4'd3: begin
                    m_rem = DC;
                    if (rt == 0) begin m_phi = m_hi; m_plo = m_lo; end
                    else begin
                        sq = sa / sb_; sr = sa % sb_;
                        m_plo = 32'(sq); m_phi = 32'(sr);
                    end
                end
                4'd4: begin
                    m_rem = DC;
                    if (rt == 0) begin m_phi = m_hi; m_plo = m_lo; end
                    else begin m_plo = rs / rt; m_phi = rs % rt; end
                end
                4'd7: m_hi = rs;
                4'd8: m_lo = rs;
                default: ;
            endcase
        end
    endtask

    // One pipeline cycle: account for the edge just taken, then present new inputs.
    task automatic cyc(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic rst_v);
        exp_t e;
        @(posedge clk);
        #2;
        model_edge(d_op, d_rs, d_rt, d_reset);
        if (!rst_v) model_edge(4'd0, 32'd0, 32'd0, 1'b0);
        reset         = rst_v;
        intf.E_MDU_Op = op;
        intf.E_RS     = rs;
        intf.E_RT     = rt;
        d_op = op; d_rs = rs; d_rt = rt; d_reset = rst_v;
        e.start  = (op >= 4'd1 && op <= 4'd4);
        e.result = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        e.busy   = (m_rem != 0);
        e.hi     = m_hi;
        e.lo     = m_lo;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(4'd0, 32'd0, 32'd0, 1'b1);
    endtask

    // Monitor: compares the DUT against the oldest expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("start",  32'(intf.E_MDU_Start), 32'(e.start));
                chk("busy",   32'(intf.E_MDU_Busy),  32'(e.busy));
                chk("result", intf.E_MDU_Result,     e.result);
                chk("hi",     intf.E_HI,             e.hi);
                chk("lo",     intf.E_LO,             e.lo);
            end
        end
    end

    initial begin
        logic [31:0] rs, rt;
        logic [3:0]  op;
        int          wait_cnt;
        reset = 1'b0;
        intf.E_MDU_Op = '0;
        intf.E_RS = '0;
        intf.E_RT = '0;

        cyc(4'd0, 32'd0, 32'd0, 1'b0);
        cyc(4'd0, 32'd0, 32'd0, 1'b0);
        cyc(4'd0, 32'd0, 32'd0, 1'b1);

        // mult / multu of -2 * 3
        cyc(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1); idle(7);
        cyc(4'd6, 32'd0, 32'd0, 1'b1);
        cyc(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b1); idle(7);

        // reset in the middle of a mult aborts it
        cyc(4'd1, 32'd5, 32'd7, 1'b1); idle(2);
        cyc(4'd0, 32'd0, 32'd0, 1'b0);
        cyc(4'd0, 32'd0, 32'd0, 1'b0);
        idle(8);

        // divides
        cyc(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1); idle(12);
        cyc(4'd4, 32'd7, 32'd2, 1'b1); idle(12);
        cyc(4'd7, 32'h11, 32'd0, 1'b1);
        cyc(4'd8, 32'h22, 32'd0, 1'b1);
        cyc(4'd4, 32'd5, 32'd0, 1'b1); idle(12);
        cyc(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); idle(12);

        // collisions while busy
        cyc(4'd1, 32'd3, 32'd4, 1'b1);
        cyc(4'd8, 32'hAA, 32'd0, 1'b1);
        cyc(4'd1, 32'd9, 32'd9, 1'b1);
        cyc(4'd6, 32'd0, 32'd0, 1'b1);
        idle(4);
        cyc(4'd6, 32'd0, 32'd0, 1'b1);

        // moves and unused opcodes
        cyc(4'd7, 32'h1234, 32'd0, 1'b1);
        cyc(4'd5, 32'd0, 32'd0, 1'b1);
        for (int k = 9; k <= 15; k++) cyc(4'(k), 32'hDEAD_BEEF, 32'h5, 1'b1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(9, 15));
            else op = 4'($urandom_range(0, 8));
            case ($urandom_range(0, 4))
                0: rs = 32'h8000_0000;
                1: rs = 32'($urandom_range(0, 20));
                default: rs = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rt = 32'd0;
                1: rt = 32'hFFFF_FFFF;
                2: rt = 32'($urandom_range(1, 9));
                default: rt = $urandom;
            endcase
            cyc(op, rs, rt, ($urandom_range(0, 199) != 0));
        end
        idle(2);

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
